ahbl_apb_bridge: RTL and testbench

// AHB-Lite slave to APB3 master bridge. It sits directly downstream of the AHB-Lite BFM master in
// the peripheral testbench and drives up to NUM_SLAVES APB peripherals, for example CoreUARTapb.

---
 rtl/ahbl_apb_bridge.sv | 156 +++++++++++++++
 tb/tb_ahbl_apb_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: each accepted AHB transfer becomes one APB SETUP/ACCESS
// cycle; bad decodes, PSLVERR and PREADY timeouts return a two-cycle AHB ERROR.
module ahbl_apb_bridge #(
  parameter int NUM_SLAVES = 16,
  parameter int SEL_LSB    = 8,
  parameter int PADDR_W    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic [PADDR_W-1:0]    PADDR,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WLATCH = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4,
    ERR1   = 3'd5,
    ERR2   = 3'd6
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              idx;
  logic [3:0]              addr_idx;
  logic [3:0]              sel_idx;
  logic                    bad_idx;
  logic                    sample_pt;
  logic                    take;
  logic                    timed_out;
  logic [CNT_W-1:0]        count;
  logic [NUM_SLAVES-1:0]   psel_nxt;
  logic                    unused;

  assign addr_idx  = HADDR[SEL_LSB+3:SEL_LSB];
  assign bad_idx   = ({1'b0, addr_idx} >= 5'(NUM_SLAVES));
  // The error fires in the ACCESS cycle where count already equals TIMEOUT with PREADY still low.
  assign timed_out = (TIMEOUT != 0) && (count == TO_VAL);
  assign unused    = ^{HSIZE, HTRANS[0], HADDR};

  // Accept decode, next-state logic and next PSEL vector.
  always_comb begin
    sample_pt = 1'b0;
    state_nxt = state;
    psel_nxt  = {NUM_SLAVES{1'b0}};
    case (state)
      IDLE, DONE, ERR2: sample_pt = 1'b1;
      default:          sample_pt = 1'b0;
    endcase
    take    = sample_pt & HSEL & HREADY & HTRANS[1];
    sel_idx = take ? addr_idx : idx;
    case (state)
      IDLE, DONE, ERR2: begin
        if (!take) begin
          state_nxt = IDLE;
        end else if (bad_idx) begin
          state_nxt = ERR1;
        end else if (HWRITE) begin
          state_nxt = WLATCH;
        end else begin
          state_nxt = SETUP;
        end
      end
      WLATCH: state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_nxt = PSLVERR ? ERR1 : DONE;
        end else if (timed_out) begin
          state_nxt = ERR1;
        end else begin
          state_nxt = ACCESS;
        end
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (((state_nxt == SETUP) || (state_nxt == ACCESS)) && (sel_idx == 4'(i))) begin
        psel_nxt[i] = 1'b1;
      end else begin
        psel_nxt[i] = 1'b0;
      end
    end
  end

  // State register plus outputs registered from the next state so they are glitch-free.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      PSEL      <= {NUM_SLAVES{1'b0}};
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= {PADDR_W{1'b0}};
      idx       <= 4'd0;
    end else begin
      state     <= state_nxt;
      HREADYOUT <= (state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == ERR2);
      HRESP     <= (state_nxt == ERR1) || (state_nxt == ERR2);
      PSEL      <= psel_nxt;
      PENABLE   <= (state_nxt == ACCESS);
      if (take) begin
        PADDR  <= HADDR[PADDR_W-1:0];
        PWRITE <= HWRITE;
        idx    <= addr_idx;
      end
    end
  end

  // Write data capture, read data return and the saturating ACCESS wait counter.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      PWDATA <= 32'd0;
      HRDATA <= 32'd0;
      count  <= {CNT_W{1'b0}};
    end else begin
      if (state == WLATCH) begin
        PWDATA <= HWDATA;
      end
      if ((state == ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
        HRDATA <= PRDATA;
      end
      if (state_nxt == SETUP) begin
        count <= {CNT_W{1'b0}};
      end else if ((state == ACCESS) && !PREADY && (count != CNT_MAX)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Directed self-checking bench for ahbl_apb_bridge (NUM_SLAVES=4, TIMEOUT=8).
module tb_ahbl_apb_bridge;

  localparam int NS = 4;

  logic          HCLK = 1'b0;
  logic          HRESETN;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [NS-1:0] PSEL;
  logic [7:0]    PADDR;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 HCLK = ~HCLK;

  // Single-slave AHB system: the bridge's own ready is the system HREADY.
  assign HREADY = HREADYOUT;

  ahbl_apb_bridge #(.NUM_SLAVES(NS), .SEL_LSB(8), .PADDR_W(8), .TIMEOUT(8)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PADDR(PADDR),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = w;
  endtask

  task automatic test_reset();
    HRESETN = 1'b0; idle_bus(); HSIZE = 3'b010; HWDATA = 32'h0;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0;
    repeat (3) step();
    total++; if (HREADYOUT !== 1'b1) begin fails++; $display("FAIL rst_hreadyout got %b want 1", HREADYOUT); end else passed++;
    total++; if (HRESP !== 1'b0) begin fails++; $display("FAIL rst_hresp got %b want 0", HRESP); end else passed++;
    total++; if (HRDATA !== 32'h0) begin fails++; $display("FAIL rst_hrdata got %h want 0", HRDATA); end else passed++;
    total++; if ({PSEL, PENABLE, PWRITE} !== 6'b0) begin fails++; $display("FAIL rst_apb_ctl got %b want 0", {PSEL, PENABLE, PWRITE}); end else passed++;
    total++; if ({PADDR, PWDATA} !== 40'h0) begin fails++; $display("FAIL rst_apb_data got %h want 0", {PADDR, PWDATA}); end else passed++;
    HRESETN = 1'b1;
    step();
    total++; if (HREADYOUT !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b want 1", HREADYOUT); end else passed++;
  endtask

  task automatic test_write();
    step();
    addr_phase(32'h0000_0104, 1'b1);
    step();
    idle_bus(); HWDATA = 32'hA5A5_0001;
    total++; if ({HREADYOUT, PSEL} !== 5'b0_0000) begin fails++; $display("FAIL wr_wlatch got %b want 00000", {HREADYOUT, PSEL}); end else passed++;
    step();
    total++; if ({PSEL, PENABLE, PWRITE, HREADYOUT} !== 7'b0010_0_1_0) begin fails++; $display("FAIL wr_setup_ctl got %b want 0010010", {PSEL, PENABLE, PWRITE, HREADYOUT}); end else passed++;
    total++; if (PADDR !== 8'h04) begin fails++; $display("FAIL wr_paddr got %h want 04", PADDR); end else passed++;
    total++; if (PWDATA !== 32'hA5A5_0001) begin fails++; $display("FAIL wr_pwdata got %h want a5a50001", PWDATA); end else passed++;
    step();
    total++; if ({PSEL, PENABLE, HREADYOUT} !== 6'b0010_1_0) begin fails++; $display("FAIL wr_access got %b want 001010", {PSEL, PENABLE, HREADYOUT}); end else passed++;
    step();
    total++; if ({HREADYOUT, HRESP, PSEL, PENABLE} !== 7'b1_0_0000_0) begin fails++; $display("FAIL wr_done got %b want 1000000", {HREADYOUT, HRESP, PSEL, PENABLE}); end else passed++;
  endtask

  task automatic test_read_wait();
    int n;
    int accs;
    step();
    addr_phase(32'h0000_0300, 1'b0); PREADY = 1'b0; PRDATA = 32'h1234_5678;
    step();
    idle_bus(); n = 1; accs = 0;
    total++; if ({PSEL, PENABLE, PWRITE} !== 6'b1000_0_0) begin fails++; $display("FAIL rd_setup got %b want 100000", {PSEL, PENABLE, PWRITE}); end else passed++;
    while (HREADYOUT !== 1'b1 && n < 20) begin
      step(); n++;
      if (PENABLE === 1'b1) begin
        accs++;
        if (accs == 4) begin
          PREADY = 1'b1;
          total++; if (HRDATA !== 32'h0) begin fails++; $display("FAIL rd_hold got %h want 0", HRDATA); end else passed++;
        end
      end
    end
    total++; if (n !== 6) begin fails++; $display("FAIL rd_latency got %0d want 6", n); end else passed++;
    total++; if (accs !== 4) begin fails++; $display("FAIL rd_access_cycles got %0d want 4", accs); end else passed++;
    total++; if (HRDATA !== 32'h1234_5678) begin fails++; $display("FAIL rd_hrdata got %h want 12345678", HRDATA); end else passed++;
    total++; if ({HRESP, PSEL} !== 5'b0) begin fails++; $display("FAIL rd_done got %b want 00000", {HRESP, PSEL}); end else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    step();
    addr_phase(32'h0000_0208, 1'b1); PRDATA = 32'hCAFE_F00D;
    step();
    addr_phase(32'h0000_020C, 1'b0); HWDATA = 32'h5A5A_0002; n = 1;
    while (HREADYOUT !== 1'b1 && n < 20) begin
      step(); n++;
      if (n == 2) begin
        total++; if ({PSEL, PWRITE, PADDR} !== 13'b0100_1_0000_1000) begin fails++; $display("FAIL b2b_wr_setup got %b want 0100100001000", {PSEL, PWRITE, PADDR}); end else passed++;
        total++; if (PWDATA !== 32'h5A5A_0002) begin fails++; $display("FAIL b2b_pwdata got %h want 5a5a0002", PWDATA); end else passed++;
      end
    end
    total++; if (n !== 4) begin fails++; $display("FAIL b2b_wr_latency got %0d want 4", n); end else passed++;
    step();
    idle_bus();
    total++; if ({PSEL, PENABLE, PWRITE, HREADYOUT} !== 7'b0100_0_0_0) begin fails++; $display("FAIL b2b_rd_setup got %b want 0100000", {PSEL, PENABLE, PWRITE, HREADYOUT}); end else passed++;
    total++; if (PADDR !== 8'h0C) begin fails++; $display("FAIL b2b_rd_paddr got %h want 0c", PADDR); end else passed++;
    step();
    total++; if (PENABLE !== 1'b1) begin fails++; $display("FAIL b2b_rd_access got %b want 1", PENABLE); end else passed++;
    step();
    total++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'hCAFE_F00D}) begin fails++; $display("FAIL b2b_rd_done got %h want 1cafef00d", {HREADYOUT, HRDATA}); end else passed++;
  endtask

  task automatic test_busy();
    step();
    HSEL = 1'b1; HADDR = 32'h0000_0104; HTRANS = 2'b01; HWRITE = 1'b1;
    step();
    HTRANS = 2'b00;
    total++; if ({HREADYOUT, HRESP, PSEL} !== 6'b1_0_0000) begin fails++; $display("FAIL busy_okay got %b want 100000", {HREADYOUT, HRESP, PSEL}); end else passed++;
    step();
    total++; if ({HREADYOUT, PSEL} !== 5'b1_0000) begin fails++; $display("FAIL idle_no_apb got %b want 10000", {HREADYOUT, PSEL}); end else passed++;
    idle_bus();
  endtask

  task automatic test_bad_decode();
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 32'h0000_0500 : 32'h0000_0400;
      step();
      addr_phase(a, 1'b0);
      step();
      idle_bus();
      total++; if ({HREADYOUT, HRESP, PSEL, PENABLE} !== 7'b0_1_0000_0) begin fails++; $display("FAIL bad_err1 addr %h got %b want 0100000", a, {HREADYOUT, HRESP, PSEL, PENABLE}); end else passed++;
      step();
      total++; if ({HREADYOUT, HRESP, PSEL} !== 6'b1_1_0000) begin fails++; $display("FAIL bad_err2 addr %h got %b want 110000", a, {HREADYOUT, HRESP, PSEL}); end else passed++;
      step();
      total++; if ({HREADYOUT, HRESP} !== 2'b10) begin fails++; $display("FAIL bad_idle addr %h got %b want 10", a, {HREADYOUT, HRESP}); end else passed++;
    end
  endtask

  task automatic test_pslverr();
    step();
    addr_phase(32'h0000_0104, 1'b0); PSLVERR = 1'b1; PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
    step();
    idle_bus();
    step();
    total++; if ({PSEL, PENABLE} !== 5'b0010_1) begin fails++; $display("FAIL slverr_access got %b want 00101", {PSEL, PENABLE}); end else passed++;
    step();
    total++; if ({HREADYOUT, HRESP, PSEL, PENABLE} !== 7'b0_1_0000_0) begin fails++; $display("FAIL slverr_err1 got %b want 0100000", {HREADYOUT, HRESP, PSEL, PENABLE}); end else passed++;
    step();
    total++; if ({HREADYOUT, HRESP} !== 2'b11) begin fails++; $display("FAIL slverr_err2 got %b want 11", {HREADYOUT, HRESP}); end else passed++;
    total++; if (HRDATA !== 32'hCAFE_F00D) begin fails++; $display("FAIL slverr_hrdata_hold got %h want cafef00d", HRDATA); end else passed++;
    PSLVERR = 1'b0;
  endtask

  task automatic test_timeout();
    int accs;
    step();
    addr_phase(32'h0000_0200, 1'b0); PREADY = 1'b0;
    step();
    idle_bus();
    step();
    accs = 0;
    while (PENABLE === 1'b1 && accs < 40) begin
      accs++;
      step();
    end
    // Count starts at 0 in the first ACCESS cycle and reaches 8 after eight waits; the error
    // decision is taken in the ninth ACCESS cycle.
    total++; if (accs !== 9) begin fails++; $display("FAIL timeout_access_cycles got %0d want 9", accs); end else passed++;
    total++; if ({HREADYOUT, HRESP, PSEL} !== 6'b0_1_0000) begin fails++; $display("FAIL timeout_err1 got %b want 010000", {HREADYOUT, HRESP, PSEL}); end else passed++;
    step();
    total++; if ({HREADYOUT, HRESP} !== 2'b11) begin fails++; $display("FAIL timeout_err2 got %b want 11", {HREADYOUT, HRESP}); end else passed++;
    PREADY = 1'b1;
  endtask

  task automatic test_reset_mid();
    step();
    addr_phase(32'h0000_0100, 1'b0); PREADY = 1'b0;
    step();
    idle_bus();
    step();
    total++; if (PENABLE !== 1'b1) begin fails++; $display("FAIL mid_pre_access got %b want 1", PENABLE); end else passed++;
    #2 HRESETN = 1'b0;
    #1;
    total++; if ({PSEL, PENABLE, HREADYOUT, HRESP, PWRITE} !== 8'b0000_0_1_0_0) begin fails++; $display("FAIL mid_rst_ctl got %b want 00000100", {PSEL, PENABLE, HREADYOUT, HRESP, PWRITE}); end else passed++;
    total++; if ({HRDATA, PWDATA, PADDR} !== 72'h0) begin fails++; $display("FAIL mid_rst_data got %h want 0", {HRDATA, PWDATA, PADDR}); end else passed++;
    step();
    HRESETN = 1'b1; PREADY = 1'b1;
    step();
    addr_phase(32'h0000_0304, 1'b1);
    step();
    idle_bus(); HWDATA = 32'h0BAD_BEEF;
    step();
    total++; if ({PSEL, PWRITE, PADDR} !== 13'b1000_1_0000_0100) begin fails++; $display("FAIL post_rst_setup got %b want 1000100000100", {PSEL, PWRITE, PADDR}); end else passed++;
    total++; if (PWDATA !== 32'h0BAD_BEEF) begin fails++; $display("FAIL post_rst_pwdata got %h want 0badbeef", PWDATA); end else passed++;
    step();
    total++; if (PENABLE !== 1'b1) begin fails++; $display("FAIL post_rst_access got %b want 1", PENABLE); end else passed++;
    step();
    total++; if ({HREADYOUT, HRESP, PSEL} !== 6'b1_0_0000) begin fails++; $display("FAIL post_rst_done got %b want 100000", {HREADYOUT, HRESP, PSEL}); end else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_busy();
    test_bad_decode();
    test_pslverr();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", total);
    $fatal(1, "watchdog");
  end

endmodule
